// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: default sizes and the checkpoint entry record.
// The predicted target lives beside the record so its width can follow the TW parameter.
package branch_resolve_unit_pkg;

    localparam int BRU_DEPTH = 2;
    localparam int BRU_IW    = 6;
    localparam int BRU_TW    = 32;

    typedef logic [BRU_IW-1:0] rob_indx_t;

    typedef struct packed {
        logic      valid;
        rob_indx_t indx;
        logic      pred_taken;
        logic      resolved;
    } brch_entry_t;

endpackage

// File: rtl/branch_resolve_unit_brch_match.sv
// Combinational lookup of a resolved ROB index against all live, unresolved checkpoints.
// Returns the lowest matching slot; ROB indices are unique among outstanding branches.
module brch_match
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = BRU_DEPTH,
    parameter int PW    = 1
) (
    input  brch_entry_t     entries_i [DEPTH],
    input  rob_indx_t       ex_indx_i,
    output logic            hit_o,
    output logic [PW-1:0]   slot_o
);

    logic            hit_s;
    logic [PW-1:0]   slot_s;
    logic            m_s;

    // priority search, descending so the lowest matching slot wins
    always_comb begin
        hit_s  = 1'b0;
        slot_s = '0;
        m_s    = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            m_s    = entries_i[i].valid && !entries_i[i].resolved &&
                     (entries_i[i].indx == ex_indx_i);
            hit_s  = hit_s | m_s;
            slot_s = m_s ? PW'(i) : slot_s;
        end
    end

    assign hit_o  = hit_s;
    assign slot_o = slot_s;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch checkpoint table: tracks in-flight branches in age order, flags mispredictions
// with a redirect, squashes younger checkpoints, and reports in-order branch commits.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = BRU_DEPTH,
    parameter int TW    = BRU_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          brch_alloc,
    input  logic [5:0]    brch_alloc_indx,
    input  logic          pred_taken,
    input  logic [TW-1:0] pred_target,
    input  logic          ex_valid,
    input  logic [5:0]    ex_indx,
    input  logic          ex_taken,
    input  logic [TW-1:0] ex_target,
    input  logic          rob_head_valid,
    input  logic [5:0]    rob_head_indx,
    output logic          brch_full,
    output logic          mis_pred,
    output logic [5:0]    brch_mis_indx,
    output logic [TW-1:0] redirect_pc,
    output logic          cmt_brch,
    output logic [5:0]    cmt_brch_indx
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    brch_entry_t   ent_q [DEPTH];
    brch_entry_t   ent_d [DEPTH];
    logic [TW-1:0] tgt_q [DEPTH];
    logic [TW-1:0] tgt_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          mis_pred_q, mis_pred_d;
    logic [5:0]    brch_mis_indx_q, brch_mis_indx_d;
    logic [TW-1:0] redirect_pc_q, redirect_pc_d;
    logic          cmt_brch_q, cmt_brch_d;
    logic [5:0]    cmt_brch_indx_q, cmt_brch_indx_d;

    logic          hit_s;
    logic [PW-1:0] slot_s;
    logic [PW-1:0] slot_off_s;
    logic          full_s, mispred_s, commit_s, alloc_s;

    brch_match #(.DEPTH(DEPTH), .PW(PW)) u_match (
        .entries_i (ent_q),
        .ex_indx_i (ex_indx),
        .hit_o     (hit_s),
        .slot_o    (slot_s)
    );

    // next-state: resolve, squash, commit and allocate, in that order of precedence
    always_comb begin
        ent_d           = ent_q;
        tgt_d           = tgt_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        full_s          = (count_q == CW'(DEPTH));
        slot_off_s      = slot_s - head_q;
        mispred_s       = ex_valid && hit_s &&
                          ((ex_taken != ent_q[slot_s].pred_taken) ||
                           (ex_taken && (ex_target != tgt_q[slot_s])));
        commit_s        = ent_q[head_q].valid && ent_q[head_q].resolved &&
                          rob_head_valid && (rob_head_indx == ent_q[head_q].indx);
        // a commit frees the head slot this cycle, so a full table can still take one
        alloc_s         = brch_alloc && !mispred_s && (!full_s || commit_s);

        mis_pred_d      = mispred_s;
        brch_mis_indx_d = mispred_s ? ex_indx : brch_mis_indx_q;
        redirect_pc_d   = mispred_s ? ex_target : redirect_pc_q;
        cmt_brch_d      = commit_s;
        cmt_brch_indx_d = commit_s ? ent_q[head_q].indx : cmt_brch_indx_q;

        if (ex_valid && hit_s) begin
            ent_d[slot_s].resolved = 1'b1;
        end else begin
            ent_d[slot_s].resolved = ent_q[slot_s].resolved;
        end

        if (mispred_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((PW'(i) - head_q) > slot_off_s) begin
                    ent_d[i].valid = 1'b0;
                end else begin
                    ent_d[i].valid = ent_q[i].valid;
                end
            end
            tail_d  = slot_s + PW'(1);
            count_d = CW'(slot_off_s) + CW'(1) - CW'(commit_s);
        end else begin
            tail_d  = tail_q + PW'(alloc_s);
            count_d = count_q + CW'(alloc_s) - CW'(commit_s);
        end

        if (commit_s) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end

        if (alloc_s) begin
            ent_d[tail_q] = '{valid: 1'b1, indx: brch_alloc_indx,
                              pred_taken: pred_taken, resolved: 1'b0};
            tgt_d[tail_q] = pred_target;
        end else begin
            tgt_d[tail_q] = tgt_q[tail_q];
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                tgt_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            mis_pred_q      <= 1'b0;
            brch_mis_indx_q <= 6'd0;
            redirect_pc_q   <= '0;
            cmt_brch_q      <= 1'b0;
            cmt_brch_indx_q <= 6'd0;
        end else begin
            ent_q           <= ent_d;
            tgt_q           <= tgt_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            mis_pred_q      <= mis_pred_d;
            brch_mis_indx_q <= brch_mis_indx_d;
            redirect_pc_q   <= redirect_pc_d;
            cmt_brch_q      <= cmt_brch_d;
            cmt_brch_indx_q <= cmt_brch_indx_d;
        end
    end

    assign brch_full     = (count_q == CW'(DEPTH));
    assign mis_pred      = mis_pred_q;
    assign brch_mis_indx = brch_mis_indx_q;
    assign redirect_pc   = redirect_pc_q;
    assign cmt_brch      = cmt_brch_q;
    assign cmt_brch_indx = cmt_brch_indx_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (DEPTH=2, TW=32) with hand-computed expectations.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        brch_alloc;
    logic [5:0]  brch_alloc_indx;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [5:0]  ex_indx;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        rob_head_valid;
    logic [5:0]  rob_head_indx;
    logic        brch_full;
    logic        mis_pred;
    logic [5:0]  brch_mis_indx;
    logic [31:0] redirect_pc;
    logic        cmt_brch;
    logic [5:0]  cmt_brch_indx;

    int errors = 0;
    int checks = 0;

    branch_resolve_unit #(.DEPTH(2), .TW(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .brch_alloc      (brch_alloc),
        .brch_alloc_indx (brch_alloc_indx),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .ex_valid        (ex_valid),
        .ex_indx         (ex_indx),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .rob_head_valid  (rob_head_valid),
        .rob_head_indx   (rob_head_indx),
        .brch_full       (brch_full),
        .mis_pred        (mis_pred),
        .brch_mis_indx   (brch_mis_indx),
        .redirect_pc     (redirect_pc),
        .cmt_brch        (cmt_brch),
        .cmt_brch_indx   (cmt_brch_indx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        brch_alloc = 1'b0; brch_alloc_indx = 6'd0; pred_taken = 1'b0; pred_target = 32'd0;
        ex_valid = 1'b0; ex_indx = 6'd0; ex_taken = 1'b0; ex_target = 32'd0;
        rob_head_valid = 1'b0; rob_head_indx = 6'd0;
    endtask

    task automatic do_alloc(input logic [5:0] ix, input logic pt, input logic [31:0] ptg);
        brch_alloc = 1'b1; brch_alloc_indx = ix; pred_taken = pt; pred_target = ptg;
    endtask

    task automatic do_ex(input logic [5:0] ix, input logic tk, input logic [31:0] tg);
        ex_valid = 1'b1; ex_indx = ix; ex_taken = tk; ex_target = tg;
    endtask

    task automatic do_retire(input logic [5:0] ix);
        rob_head_valid = 1'b1; rob_head_indx = ix;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        chk("rst_mis_pred", 64'(mis_pred), 64'd0);
        chk("rst_cmt_brch", 64'(cmt_brch), 64'd0);
        chk("rst_full", 64'(brch_full), 64'd0);
        chk("rst_mis_indx", 64'(brch_mis_indx), 64'd0);
        chk("rst_cmt_indx", 64'(cmt_brch_indx), 64'd0);
        chk("rst_redirect", 64'(redirect_pc), 64'd0);
        rst = 1'b0;

        // correct not-taken prediction then commit
        idle(); do_alloc(6'd5, 1'b0, 32'd0); step();
        idle(); do_alloc(6'd9, 1'b0, 32'd0); step();
        chk("a_full", 64'(brch_full), 64'd1);
        idle(); do_ex(6'd5, 1'b0, 32'h1234); step();
        chk("a_no_mispred", 64'(mis_pred), 64'd0);
        idle(); do_retire(6'd5); step();
        chk("a_cmt", 64'(cmt_brch), 64'd1);
        chk("a_cmt_indx", 64'(cmt_brch_indx), 64'd5);
        chk("a_count", 64'(dut.count_q), 64'd1);
        idle(); step();
        chk("a_cmt_pulse_end", 64'(cmt_brch), 64'd0);
        idle(); do_ex(6'd9, 1'b0, 32'h0); step();
        idle(); do_retire(6'd9); step();
        chk("a_cmt9_indx", 64'(cmt_brch_indx), 64'd9);
        chk("a_count0", 64'(dut.count_q), 64'd0);

        // direction mispredict squashes the younger entry
        idle(); do_alloc(6'd5, 1'b0, 32'd0); step();
        idle(); do_alloc(6'd9, 1'b0, 32'd0); step();
        idle(); do_ex(6'd5, 1'b1, 32'h40); step();
        chk("b_mis_pred", 64'(mis_pred), 64'd1);
        chk("b_mis_indx", 64'(brch_mis_indx), 64'd5);
        chk("b_redirect", 64'(redirect_pc), 64'h40);
        chk("b_count", 64'(dut.count_q), 64'd1);
        chk("b_full", 64'(brch_full), 64'd0);
        idle(); step();
        chk("b_pulse_end", 64'(mis_pred), 64'd0);
        idle(); do_ex(6'd9, 1'b1, 32'h80); step();
        chk("b_squashed_ignored", 64'(mis_pred), 64'd0);
        idle(); do_retire(6'd5); step();
        chk("b_cmt_indx", 64'(cmt_brch_indx), 64'd5);
        chk("b_count0", 64'(dut.count_q), 64'd0);

        // full table drops alloc; commit plus alloc keeps count at 2
        idle(); do_alloc(6'd3, 1'b0, 32'd0); step();
        idle(); do_alloc(6'd4, 1'b0, 32'd0); step();
        idle(); do_alloc(6'd7, 1'b0, 32'd0); step();
        chk("c_full", 64'(brch_full), 64'd1);
        chk("c_drop_count", 64'(dut.count_q), 64'd2);
        idle(); do_ex(6'd3, 1'b0, 32'd0); step();
        idle(); do_retire(6'd3); do_alloc(6'd7, 1'b0, 32'd0); step();
        chk("c_cmt3", 64'(cmt_brch_indx), 64'd3);
        chk("c_count2", 64'(dut.count_q), 64'd2);
        chk("c_full2", 64'(brch_full), 64'd1);
        idle(); do_ex(6'd4, 1'b0, 32'd0); step();
        idle(); do_retire(6'd4); step();
        chk("c_cmt4", 64'(cmt_brch_indx), 64'd4);
        idle(); do_ex(6'd7, 1'b0, 32'd0); step();
        idle(); do_retire(6'd7); step();
        chk("c_cmt7", 64'(cmt_brch_indx), 64'd7);
        chk("c_count0", 64'(dut.count_q), 64'd0);

        // target mispredict with a wrong-path alloc in the same cycle
        idle(); do_alloc(6'd12, 1'b1, 32'h100); step();
        idle(); do_ex(6'd12, 1'b1, 32'h104); do_alloc(6'd13, 1'b0, 32'd0); step();
        chk("d_mis_pred", 64'(mis_pred), 64'd1);
        chk("d_mis_indx", 64'(brch_mis_indx), 64'd12);
        chk("d_redirect", 64'(redirect_pc), 64'h104);
        chk("d_alloc_dropped", 64'(dut.count_q), 64'd1);
        idle(); do_retire(6'd12); step();
        chk("d_cmt12", 64'(cmt_brch_indx), 64'd12);
        idle(); do_alloc(6'd20, 1'b1, 32'h200); step();
        idle(); do_ex(6'd20, 1'b1, 32'h200); step();
        chk("d_taken_correct", 64'(mis_pred), 64'd0);
        idle(); do_retire(6'd20); step();
        chk("d_cmt20", 64'(cmt_brch_indx), 64'd20);

        // unmatched index and repeated resolution are ignored
        idle(); do_alloc(6'd21, 1'b0, 32'd0); step();
        idle(); do_ex(6'd30, 1'b1, 32'h999); step();
        chk("e_nomatch", 64'(mis_pred), 64'd0);
        chk("e_nomatch_count", 64'(dut.count_q), 64'd1);
        idle(); do_ex(6'd21, 1'b1, 32'h300); step();
        chk("e_mis_pred", 64'(mis_pred), 64'd1);
        chk("e_redirect", 64'(redirect_pc), 64'h300);
        idle(); do_ex(6'd21, 1'b1, 32'h500); step();
        chk("e_repeat_mis", 64'(mis_pred), 64'd0);
        chk("e_repeat_pc", 64'(redirect_pc), 64'h300);
        idle(); do_retire(6'd21); step();
        chk("e_cmt21", 64'(cmt_brch_indx), 64'd21);

        // reset mid-operation with a mispredict in flight
        idle(); do_alloc(6'd40, 1'b0, 32'd0); step();
        idle(); do_alloc(6'd41, 1'b0, 32'd0); step();
        idle(); do_ex(6'd41, 1'b1, 32'h77); rst = 1'b1; step();
        chk("f_mis_pred", 64'(mis_pred), 64'd0);
        chk("f_full", 64'(brch_full), 64'd0);
        chk("f_redirect", 64'(redirect_pc), 64'd0);
        chk("f_mis_indx", 64'(brch_mis_indx), 64'd0);
        chk("f_cmt", 64'(cmt_brch), 64'd0);
        rst = 1'b0;
        idle(); do_alloc(6'd50, 1'b0, 32'd0); step();
        chk("f_head", 64'(dut.head_q), 64'd0);
        chk("f_tail", 64'(dut.tail_q), 64'd1);
        chk("f_count", 64'(dut.count_q), 64'd1);
        idle(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DEPTH, default 2, number of outstanding branch checkpoints; power of two; matches the allocation-side checkpoint capacity.
REQ-002 Parameter TW, default 32, target-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 brch_alloc  in  1  a branch is being allocated this cycle.
REQ-006 brch_alloc_indx  in  6  ROB index of the allocated branch.
REQ-007 pred_taken / pred_target  in  1 / TW  front-end prediction for the allocated branch.
REQ-008 ex_valid  in  1  execution result valid.
REQ-009 ex_indx / ex_taken / ex_target  in  6 / 1 / TW  resolved branch index, direction, target.
REQ-010 rob_head_valid / rob_head_indx  in  1 / 6  ROB head is retiring the instruction at this index.
REQ-011 brch_full  out  1  table full; allocation must stall.
REQ-012 mis_pred / brch_mis_indx  out  1 / 6  one-cycle misprediction pulse and offending branch index.
REQ-013 redirect_pc  out  TW  correct fetch address, valid with mis_pred.
REQ-014 cmt_brch / cmt_brch_indx  out  1 / 6  one-cycle branch-commit pulse and index.

Function
REQ-015 Entries held in age order as a circular FIFO with head, tail and count; entry fields: valid, indx, pred_taken, pred_target, resolved.
REQ-016 brch_full = (count == DEPTH), from registered count only.
REQ-017 brch_alloc with !brch_full writes the entry at tail and increments tail/count; brch_alloc while full is dropped, no state change.
REQ-018 ex_valid matching a valid, unresolved entry's indx sets resolved; no match or an already-resolved match is ignored.
REQ-019 Mispredict when matched and (ex_taken != pred_taken) or (ex_taken and ex_target != pred_target).
REQ-020 Mispredict at edge N: mis_pred=1, brch_mis_indx=ex_indx, redirect_pc = ex_taken ? ex_target : ex_indx-based fall-through supplied as ex_target by execute (unit outputs ex_target unchanged), for cycle N+1 only.
REQ-021 Mispredict invalidates all entries younger than the matched entry: tail = matched slot + 1, count recomputed; matched entry remains, resolved.
REQ-022 brch_alloc in the same cycle as a mispredict is dropped (it is on the wrong path).
REQ-023 Commit when head entry valid and resolved and rob_head_valid and rob_head_indx == head.indx: cmt_brch=1, cmt_brch_indx=head.indx next cycle for one cycle; head advances, count decrements.
REQ-024 Commit and allocation in the same cycle both take effect; count net unchanged.
REQ-025 Commit and mispredict of a younger entry in the same cycle both take effect; count = entries from new head to new tail.
REQ-026 Pointers wrap modulo DEPTH; index comparisons are exact 6-bit equality.
REQ-027 mis_pred and cmt_brch never assert for an invalid entry; at most one of each per cycle.

Reset
REQ-028 rst at edge clears head, tail, count, all valid and resolved bits; mis_pred, cmt_brch, brch_full = 0; brch_mis_indx, cmt_brch_indx, redirect_pc = 0.
REQ-029 rst mid-operation discards all entries and any pending pulse; inputs in the reset cycle are ignored.

Structure
REQ-030 Shared package holds DEPTH default, ROB index width (6), TW, and the entry record type.
REQ-031 One sub-module, brch_match: combinational compare of ex_indx against all entries, returning hit and slot; everything else in branch_resolve_unit.

Verification
REQ-032 Alloc 5,9 (pred not-taken); ex 5 not-taken; head 5 retires -> no mis_pred, cmt_brch=1 indx 5 one cycle later, count=1.
REQ-033 Alloc 5,9; ex 5 taken target 0x40 -> next cycle mis_pred=1, brch_mis_indx=5, redirect_pc=0x40; entry 9 removed, count=1.
REQ-034 DEPTH=2: alloc 3,4, then alloc 7 -> brch_full=1, 7 dropped; retire 3 with alloc 7 same cycle -> count stays 2, entries {4,7}.
REQ-035 Alloc 12 pred taken 0x100; ex 12 taken 0x104 -> mis_pred, redirect_pc=0x104; simultaneous alloc 13 dropped.
REQ-036 Ex_valid indx 30 with no entry; repeat ex on resolved entry -> no output change.
REQ-037 Rst asserted with two entries and a pending mispredict -> all outputs 0 next cycle, brch_full=0, later alloc lands in slot 0.
